// File: rtl/maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maze_game_ctrl
// Description : Game-flow sequencer for the maze: level, countdown, outcome.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_game_ctrl #(
    parameter int         NUM_LEVELS  = 2,
    parameter int         LVL_W       = 1,
    parameter logic [3:0] TIME_TENS   = 4'd3,
    parameter logic [3:0] TIME_ONES   = 4'd0,
    parameter int         RESULT_HOLD = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             pause,
    input  logic             win,
    input  logic             tick_1hz,
    output logic [2:0]       state,
    output logic [LVL_W-1:0] level,
    output logic             load_level,
    output logic             move_en,
    output logic [3:0]       time_tens,
    output logic [3:0]       time_ones,
    output logic             time_up,
    output logic [1:0]       disp_mode,
    output logic [3:0]       cleared
);

    localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

    localparam logic [HOLD_W-1:0] C_HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);
    localparam logic [LVL_W-1:0]  C_LEVEL_LAST = LVL_W'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t            state_q,      state_d;
    logic [LVL_W-1:0]  level_q,      level_d;
    logic [3:0]        tens_q,       tens_d;
    logic [3:0]        ones_q,       ones_d;
    logic [3:0]        cleared_q,    cleared_d;
    logic [HOLD_W-1:0] hold_q,       hold_d;
    logic              load_level_q, load_level_d;
    logic              move_en_q,    move_en_d;
    logic              time_up_q,    time_up_d;
    logic [1:0]        disp_mode_q,  disp_mode_d;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            tens_q       <= TIME_TENS;
            ones_q       <= TIME_ONES;
            cleared_q    <= 4'd0;
            hold_q       <= '0;
            load_level_q <= 1'b0;
            move_en_q    <= 1'b0;
            time_up_q    <= 1'b0;
            disp_mode_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            cleared_q    <= cleared_d;
            hold_q       <= hold_d;
            load_level_q <= load_level_d;
            move_en_q    <= move_en_d;
            time_up_q    <= time_up_d;
            disp_mode_q  <= disp_mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        cleared_d = cleared_q;
        hold_d    = hold_q;

        case (state_q)
            S_IDLE: begin
                if (start_pulse) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                // A win on the same tick that would expire the clock still counts.
                if (win) begin
                    state_d = S_WIN;
                    hold_d  = '0;
                    if (cleared_q != 4'hF) cleared_d = cleared_q + 4'd1;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else if (tick_1hz) begin
                    if (tens_q == 4'd0 && ones_q == 4'd0) begin
                        state_d = S_LOSE;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (!pause) state_d = S_PLAY;
            end
            S_WIN: begin
                if (tick_1hz) begin
                    if (hold_q == C_HOLD_LAST) begin
                        if (level_q == C_LEVEL_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            level_d = level_q + LVL_W'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            S_LOSE: begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                if (start_pulse) state_d = S_LOAD;
            end
            S_DONE: begin
                if (start_pulse) begin
                    level_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reload on entry so the fresh time is already visible during LOAD.
        if (state_d == S_LOAD) begin
            tens_d = TIME_TENS;
            ones_d = TIME_ONES;
        end

        load_level_d = (state_d == S_LOAD);
        move_en_d    = (state_d == S_PLAY);
        time_up_d    = (state_d == S_LOSE);
        case (state_d)
            S_WIN:   disp_mode_d = 2'd1;
            S_LOSE:  disp_mode_d = 2'd2;
            S_DONE:  disp_mode_d = 2'd3;
            default: disp_mode_d = 2'd0;
        endcase
    end

    assign state      = state_q;
    assign level      = level_q;
    assign load_level = load_level_q;
    assign move_en    = move_en_q;
    assign time_tens  = tens_q;
    assign time_ones  = ones_q;
    assign time_up    = time_up_q;
    assign disp_mode  = disp_mode_q;
    assign cleared    = cleared_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_game_ctrl
// Description : Directed game script plus random play against a seconds-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_game_ctrl;

    localparam int NUM_LEVELS  = 2;
    localparam int LVL_W       = 1;
    localparam int RESULT_HOLD = 3;
    localparam int START_SECS  = 30;

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic             start_pulse = 1'b0;
    logic             pause = 1'b0;
    logic             win = 1'b0;
    logic             tick_1hz = 1'b0;
    logic [2:0]       state;
    logic [LVL_W-1:0] level;
    logic             load_level;
    logic             move_en;
    logic [3:0]       time_tens;
    logic [3:0]       time_ones;
    logic             time_up;
    logic [1:0]       disp_mode;
    logic [3:0]       cleared;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    maze_game_ctrl #(
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W),
        .TIME_TENS  (4'd3),
        .TIME_ONES  (4'd0),
        .RESULT_HOLD(RESULT_HOLD)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start_pulse(start_pulse),
        .pause      (pause),
        .win        (win),
        .tick_1hz   (tick_1hz),
        .state      (state),
        .level      (level),
        .load_level (load_level),
        .move_en    (move_en),
        .time_tens  (time_tens),
        .time_ones  (time_ones),
        .time_up    (time_up),
        .disp_mode  (disp_mode),
        .cleared    (cleared)
    );

    always #10 clk_in = ~clk_in;

    // Game model: plain integers, time kept as whole seconds remaining.
    int m_state = 0, m_level = 0, m_secs = START_SECS, m_cleared = 0, m_hold = 0;

    always @(posedge clk_in) begin : model
        int st, lv, secs, cl, hd;
        st = m_state; lv = m_level; secs = m_secs; cl = m_cleared; hd = m_hold;
        if (rst) begin
            st = 0; lv = 0; secs = START_SECS; cl = 0; hd = 0;
        end else begin
            case (m_state)
                0: if (start_pulse) begin st = 1; secs = START_SECS; end
                1: st = 2;
                2: begin
                    if (win) begin
                        st = 4; hd = 0; cl = (cl < 15) ? cl + 1 : 15;
                    end else if (pause) st = 3;
                    else if (tick_1hz) begin
                        if (secs == 0) st = 5;
                        else secs = secs - 1;
                    end
                end
                3: if (!pause) st = 2;
                4: if (tick_1hz) begin
                    if (hd == RESULT_HOLD - 1) begin
                        if (lv == NUM_LEVELS - 1) st = 6;
                        else begin lv = lv + 1; st = 1; secs = START_SECS; end
                    end else hd = hd + 1;
                end
                5: begin
                    secs = 0;
                    if (start_pulse) begin st = 1; secs = START_SECS; end
                end
                6: if (start_pulse) begin lv = 0; st = 1; secs = START_SECS; end
                default: st = 0;
            endcase
        end
        m_state <= st; m_level <= lv; m_secs <= secs; m_cleared <= cl; m_hold <= hd;
    end

    function automatic logic [23:0] expected_outputs();
        int dm;
        dm = (m_state == 4) ? 1 : (m_state == 5) ? 2 : (m_state == 6) ? 3 : 0;
        return {3'(m_state), 1'(m_level), (m_state == 1), (m_state == 2),
                4'(m_secs / 10), 4'(m_secs % 10), (m_state == 5), 2'(dm), 4'(m_cleared)};
    endfunction

    always @(negedge clk_in) begin
        logic [23:0] act, exp_v;
        if (chk_en) begin
            act   = {state, level, load_level, move_en, time_tens, time_ones,
                     time_up, disp_mode, cleared};
            exp_v = expected_outputs();
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t actual=%h expected=%h (st/lv/ld/mv/tt/to/tu/dm/cl)",
                         $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Inputs held for one full cycle, from one falling edge to the next.
    task automatic step(input bit s, input bit p, input bit w, input bit t);
        start_pulse = s; pause = p; win = w; tick_1hz = t;
        @(negedge clk_in);
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_state", state, 0);
        check("reset_time", {time_tens, time_ones}, 8'h30);
        check("reset_cleared", cleared, 0);

        step(1, 0, 0, 0);
        check("load_state", state, 1);
        check("load_pulse", load_level, 1);
        step(1, 0, 0, 0);
        check("play_state", state, 2);
        check("play_load_low", load_level, 0);
        check("play_move_en", move_en, 1);

        for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
        check("time_00", {time_tens, time_ones}, 8'h00);
        step(0, 0, 0, 1);
        check("lose_state", state, 5);
        check("lose_time_up", time_up, 1);
        check("lose_disp", disp_mode, 2);
        step(1, 0, 0, 0);
        check("retry_load", state, 1);
        check("retry_time", {time_tens, time_ones}, 8'h30);
        step(0, 0, 0, 0);

        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        check("pause_state", state, 3);
        check("pause_time", {time_tens, time_ones}, 8'h29);
        check("pause_move_en", move_en, 0);
        step(0, 0, 0, 0);
        check("unpause_state", state, 2);

        for (int i = 0; i < 29; i++) step(0, 0, 0, 1);
        check("time_00_b", {time_tens, time_ones}, 8'h00);
        step(0, 0, 1, 1);
        check("win_state", state, 4);
        check("win_cleared", cleared, 1);
        check("win_disp", disp_mode, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("next_level_load", state, 1);
        check("next_level", level, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("done_state", state, 6);
        check("done_disp", disp_mode, 3);
        step(1, 0, 0, 0);
        check("restart_level", level, 0);
        check("restart_cleared", cleared, 2);

        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        rst = 1'b1;
        step(0, 0, 0, 1);
        rst = 1'b0;
        check("rst_win_state", state, 0);
        check("rst_win_cleared", cleared, 0);
        check("rst_win_disp", disp_mode, 0);

        begin
            bit p = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) p = ~p;
                rst = ($urandom_range(299) == 0);
                step($urandom_range(7) == 0, p, $urandom_range(79) == 0,
                     $urandom_range(1) == 0);
            end
        end
        rst = 1'b0;
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
